lc3b_fetch_stage: RTL and testbench
===================================

# lc3b_fetch_stage

Front end of the pipelined LC-3b. It owns the PC, issues instruction reads to the instruction memory port, and holds the IF/ID pipeline register. The decoded IF/ID source fields it publishes feed the hazard detection unit, and it obeys that unit's load-enable back. It buffers a returned instruction when the pipe cannot accept it, and squashes wrong-path fetches on a taken branch.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_address  out  16  fetch address. Driven from a registered fetch address and held stable while imem_read is 1.
- imem_read  out  1  read request. Held until imem_resp.
- imem_rdata  in  16  instruction word. Valid when imem_resp is 1.
- imem_resp  in  1  read complete. Single-cycle pulse.
- load_if_id  in  1  load-enable from hazard detection. 0 means a load-use stall.
- pipe_stall  in  1  global freeze from the memory stage.
- branch_taken  in  1  redirect request, resolved downstream.
- branch_target  in  16  redirect PC.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_ir  out  16  IF/ID instruction word.
- if_id_pc  out  16  fetch PC + 2.
- if_id_opcode  out  lc3b_opcode  if_id_ir[15:12].
- if_id_sr1  out  lc3b_reg  if_id_ir[8:6].
- if_id_sr2  out  lc3b_reg  if_id_ir[2:0].
- if_id_bit5  out  1  if_id_ir[5].
- if_id_bit11  out  1  if_id_ir[11].

## Operation
- advance = load_if_id & ~pipe_stall. flush = branch_taken & ~pipe_stall.
- When flush and advance are both active, flush has priority.
- Fetch address register fa is loaded from pc each time the block enters FETCH.
- The state machine has three states: FETCH, HOLD, DRAIN.
- FETCH: imem_read = 1, imem_address = fa.
  - resp & flush: discard rdata. pc ← target. IF/ID ← bubble. Stay in FETCH with fa ← target.
  - resp & advance: IF/ID ← {1, rdata, fa+2}. pc ← fa+2. Stay in FETCH with fa ← fa+2.
  - resp & ~advance: buf ← rdata. Go to HOLD. IF/ID unchanged.
  - ~resp & flush: pc ← target. IF/ID ← bubble. Go to DRAIN. fa is not changed, so imem_address stays stable.
  - ~resp & advance: IF/ID ← bubble.
  - Otherwise: hold.
- HOLD: imem_read = 0.
  - flush: drop buf. pc ← target. IF/ID ← bubble. Go to FETCH with fa ← target.
  - advance: IF/ID ← {1, buf, fa+2}. pc ← fa+2. Go to FETCH with fa ← fa+2.
  - Otherwise: hold.
- DRAIN: imem_read = 1 on the stale fa. The response is discarded.
  - On resp: go to FETCH with fa ← pc.
  - flush while in DRAIN: pc ← the new target only.
  - advance while in DRAIN: IF/ID ← bubble.
- A bubble is IF/ID ← {valid 0, ir 16'h0000, pc 16'h0000}. An ir of 0x0000 decodes as BR, which is not a register reader, so a bubble never raises a hazard.
- When neither advance nor flush applies, IF/ID holds its contents.
- PC arithmetic is 16-bit modulo. 0xFFFE + 2 wraps to 0x0000.

## Timing
- Reset values: state FETCH, pc = fa = RESET_PC, buf = 0, if_id_valid = 0, if_id_ir = 0, if_id_pc = 0, imem_read = 0 in the reset cycle.
- imem_read rises to 1 in the first cycle after rst deasserts.
- Latency: a response in cycle n with advance = 1 gives a valid IF/ID in cycle n+1. The next request address is visible in n+1.
- Throughput: one instruction per cycle with a same-cycle-resp memory.
- Stall release from HOLD: IF/ID loads on the edge where advance = 1. The new request issues the following cycle.
- rst mid-request: the in-flight read is abandoned and state returns to FETCH at RESET_PC. The memory is required to tolerate imem_read dropping.
- All outputs are registered or decoded from registers. There is no combinational path from input to output except through state.

## Structure
- lc3b_types supplies lc3b_word, lc3b_opcode, and lc3b_reg.
- lc3b_types gains a localparam for the bubble word 16'h0000.
- The state enum is local to this module.
- One natural sub-module is if_id_reg. It holds valid, ir, and pc, with load and clear inputs, and decodes the field outputs.

## Test plan
- Reset, then 1-cycle-resp memory returning 0x1261, 0x5042 → IF/ID shows (0x1261, pc 0x0002), then (0x5042, 0x0004). imem_address reads 0x0000, 0x0002, 0x0004.
- resp arrives while load_if_id = 0 for 3 cycles → state HOLD, imem_read = 0, IF/ID unchanged. On release, IF/ID gets the buffered word in one cycle.
- branch_taken with target 0x0040 while resp is low in FETCH → DRAIN. imem_address is held until resp, the stale word is discarded, and the next fetch is at 0x0040 with if_id_valid = 0 throughout.
- pipe_stall = 1 together with branch_taken = 1 → no redirect and no IF/ID change until pipe_stall drops.
- Fetch at 0xFFFE → if_id_pc = 0x0000 and the next fetch address is 0x0000.
- rst asserted in the middle of HOLD → all outputs at reset values the next cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/lc3b_types_pkg.sv
// Purpose: shared LC-3b datapath types used by the fetch stage.
// Provides the word, opcode and register-index types plus the bubble word.
package lc3b_types;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned OP_W   = 4;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [REG_W-1:0]  lc3b_reg;

    typedef enum logic [OP_W-1:0] {
        OP_BR    = 4'h0,
        OP_ADD   = 4'h1,
        OP_LDB   = 4'h2,
        OP_STB   = 4'h3,
        OP_JSR   = 4'h4,
        OP_AND   = 4'h5,
        OP_LDW   = 4'h6,
        OP_STW   = 4'h7,
        OP_RTI   = 4'h8,
        OP_NOT   = 4'h9,
        OP_RSV_A = 4'ha,
        OP_RSV_B = 4'hb,
        OP_JMP   = 4'hc,
        OP_SHF   = 4'hd,
        OP_LEA   = 4'he,
        OP_TRAP  = 4'hf
    } lc3b_opcode;

    // Decodes as BR, which reads no registers, so bubbles never raise hazards.
    localparam lc3b_word BUBBLE_WORD = 16'h0000;

endpackage

// File: rtl/lc3b_fetch_stage_if_id_reg.sv
// Purpose: IF/ID pipeline register with load/clear and source-field decode.
// Ports: clk, rst (sync, active-high); i_load/i_clear (clear wins);
//        i_ir/i_pc payload; o_valid/o_ir/o_pc and decoded field outputs.
module lc3b_fetch_stage_if_id_reg
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_clear,
    input  lc3b_word   i_ir,
    input  lc3b_word   i_pc,
    output logic       o_valid,
    output lc3b_word   o_ir,
    output lc3b_word   o_pc,
    output lc3b_opcode o_opcode,
    output lc3b_reg    o_sr1,
    output lc3b_reg    o_sr2,
    output logic       o_bit5,
    output logic       o_bit11
);

    logic     r_valid;
    lc3b_word r_ir;
    lc3b_word r_pc;

    // Register update: clear inserts a bubble, load captures a fetched word.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
            r_ir    <= BUBBLE_WORD;
            r_pc    <= 16'h0000;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ir    <= i_ir;
            r_pc    <= i_pc;
        end
    end

    assign o_valid  = r_valid;
    assign o_ir     = r_ir;
    assign o_pc     = r_pc;
    assign o_opcode = lc3b_opcode'(r_ir[15:12]);
    assign o_sr1    = r_ir[8:6];
    assign o_sr2    = r_ir[2:0];
    assign o_bit5   = r_ir[5];
    assign o_bit11  = r_ir[11];

endmodule

// File: rtl/lc3b_fetch_stage.sv
// Purpose: LC-3b fetch stage: PC, instruction-memory requests, response
// buffering while stalled, wrong-path squash on taken branches, IF/ID register.
// Ports: clk, rst; imem_* request/response; load_if_id, pipe_stall,
//        branch_taken/branch_target control; if_id_* pipeline outputs.
module lc3b_fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    output lc3b_word   imem_address,
    output logic       imem_read,
    input  lc3b_word   imem_rdata,
    input  logic       imem_resp,
    input  logic       load_if_id,
    input  logic       pipe_stall,
    input  logic       branch_taken,
    input  lc3b_word   branch_target,
    output logic       if_id_valid,
    output lc3b_word   if_id_ir,
    output lc3b_word   if_id_pc,
    output lc3b_opcode if_id_opcode,
    output lc3b_reg    if_id_sr1,
    output lc3b_reg    if_id_sr2,
    output logic       if_id_bit5,
    output logic       if_id_bit11
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t   r_state;
    lc3b_word r_pc;
    lc3b_word r_fa;
    lc3b_word r_buf;
    logic     r_read;

    logic     w_advance;
    logic     w_flush;
    lc3b_word w_fa_plus2;
    logic     w_ifid_load;
    logic     w_ifid_clear;
    lc3b_word w_ifid_ir;

    assign w_advance  = load_if_id & ~pipe_stall;
    assign w_flush    = branch_taken & ~pipe_stall;
    assign w_fa_plus2 = r_fa + 16'd2;

    // IF/ID load/clear decode; flush outranks advance.
    always_comb begin
        w_ifid_load  = 1'b0;
        w_ifid_clear = 1'b0;
        w_ifid_ir    = imem_rdata;
        case (r_state)
            S_FETCH: begin
                if (imem_resp) begin
                    if (w_flush)        w_ifid_clear = 1'b1;
                    else if (w_advance) w_ifid_load  = 1'b1;
                end else if (w_flush || w_advance) begin
                    w_ifid_clear = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_flush) begin
                    w_ifid_clear = 1'b1;
                end else if (w_advance) begin
                    w_ifid_load = 1'b1;
                    w_ifid_ir   = r_buf;
                end
            end
            S_DRAIN: begin
                // A redirect during drain only retargets the PC.
                if (!w_flush && w_advance) w_ifid_clear = 1'b1;
            end
            default: ;
        endcase
    end

    // Fetch FSM; imem_read is registered and low only while holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_fa    <= RESET_PC;
            r_buf   <= 16'h0000;
            r_read  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_read <= 1'b1;
                    if (imem_resp) begin
                        if (w_flush) begin
                            r_pc <= branch_target;
                            r_fa <= branch_target;
                        end else if (w_advance) begin
                            r_pc <= w_fa_plus2;
                            r_fa <= w_fa_plus2;
                        end else begin
                            r_buf   <= imem_rdata;
                            r_state <= S_HOLD;
                            r_read  <= 1'b0;
                        end
                    end else if (w_flush) begin
                        // Keep fa so the outstanding request stays stable.
                        r_pc    <= branch_target;
                        r_state <= S_DRAIN;
                    end
                end
                S_HOLD: begin
                    if (w_flush) begin
                        r_pc    <= branch_target;
                        r_fa    <= branch_target;
                        r_state <= S_FETCH;
                        r_read  <= 1'b1;
                    end else if (w_advance) begin
                        r_pc    <= w_fa_plus2;
                        r_fa    <= w_fa_plus2;
                        r_state <= S_FETCH;
                        r_read  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_read <= 1'b1;
                    if (w_flush) r_pc <= branch_target;
                    if (imem_resp) begin
                        // Stale word is dropped; restart at the redirected PC.
                        r_fa    <= w_flush ? branch_target : r_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_address = r_fa;
    assign imem_read    = r_read;

    lc3b_fetch_stage_if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_ifid_load),
        .i_clear  (w_ifid_clear),
        .i_ir     (w_ifid_ir),
        .i_pc     (w_fa_plus2),
        .o_valid  (if_id_valid),
        .o_ir     (if_id_ir),
        .o_pc     (if_id_pc),
        .o_opcode (if_id_opcode),
        .o_sr1    (if_id_sr1),
        .o_sr2    (if_id_sr2),
        .o_bit5   (if_id_bit5),
        .o_bit11  (if_id_bit11)
    );

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Purpose: directed self-checking bench for lc3b_fetch_stage with a
// same-cycle-response instruction memory and an expected IF/ID queue.
module tb_lc3b_fetch_stage;
    import lc3b_types::*;

    logic       clk;
    logic       rst;
    lc3b_word   imem_address;
    logic       imem_read;
    lc3b_word   imem_rdata;
    logic       imem_resp;
    logic       load_if_id;
    logic       pipe_stall;
    logic       branch_taken;
    lc3b_word   branch_target;
    logic       if_id_valid;
    lc3b_word   if_id_ir;
    lc3b_word   if_id_pc;
    lc3b_opcode if_id_opcode;
    lc3b_reg    if_id_sr1;
    lc3b_reg    if_id_sr2;
    logic       if_id_bit5;
    logic       if_id_bit11;

    logic       mem_on;
    int         checks;
    int         errors;
    logic [31:0] exp_q[$];

    lc3b_fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_address  (imem_address),
        .imem_read     (imem_read),
        .imem_rdata    (imem_rdata),
        .imem_resp     (imem_resp),
        .load_if_id    (load_if_id),
        .pipe_stall    (pipe_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_ir      (if_id_ir),
        .if_id_pc      (if_id_pc),
        .if_id_opcode  (if_id_opcode),
        .if_id_sr1     (if_id_sr1),
        .if_id_sr2     (if_id_sr2),
        .if_id_bit5    (if_id_bit5),
        .if_id_bit11   (if_id_bit11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic lc3b_word mem_word(input lc3b_word a);
        case (a)
            16'h0000: return 16'h1261;
            16'h0002: return 16'h5042;
            default:  return {a[7:0] ^ 8'h3c, a[15:8] ^ 8'hc3};
        endcase
    endfunction

    // Memory answers in the same cycle whenever enabled and a read is pending.
    always_comb begin
        imem_resp  = mem_on & imem_read;
        imem_rdata = mem_word(imem_address);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input lc3b_word ir, input lc3b_word pc);
        exp_q.push_back({ir, pc});
    endtask

    // Pops the next expected IF/ID instruction and compares it.
    task automatic chk_ifid(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {15'd0, if_id_valid, if_id_ir}, {15'd0, 1'b1, e[31:16]});
            chk({tag, "_pc"}, {16'd0, if_id_pc}, {16'd0, e[15:0]});
        end
    endtask

    task automatic chk_bubble(input string tag);
        chk(tag, {15'd0, if_id_valid, if_id_ir}, 32'd0);
        chk({tag, "_pc"}, {16'd0, if_id_pc}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; mem_on = 1'b0; load_if_id = 1'b1; pipe_stall = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0000;

        // Reset state
        tick(); tick();
        chk("rst_read", {31'd0, imem_read}, 32'd0);
        chk("rst_addr", {16'd0, imem_address}, 32'd0);
        chk_bubble("rst_ifid");

        // Straight-line fetch
        rst = 1'b0; mem_on = 1'b1;
        tick();
        chk("start_read", {31'd0, imem_read}, 32'd1);
        chk("start_addr", {16'd0, imem_address}, 32'h0000);
        chk("start_valid", {31'd0, if_id_valid}, 32'd0);
        push_exp(16'h1261, 16'h0002);
        tick();
        chk_ifid("fetch0");
        chk("fetch0_op", {28'd0, 4'(if_id_opcode)}, 32'd1);
        chk("fetch0_sr1", {29'd0, if_id_sr1}, 32'd1);
        chk("fetch0_sr2", {29'd0, if_id_sr2}, 32'd1);
        chk("fetch0_b5", {31'd0, if_id_bit5}, 32'd1);
        chk("fetch0_b11", {31'd0, if_id_bit11}, 32'd0);
        chk("addr2", {16'd0, imem_address}, 32'h0002);
        push_exp(16'h5042, 16'h0004);
        tick();
        chk_ifid("fetch1");
        chk("fetch1_op", {28'd0, 4'(if_id_opcode)}, 32'd5);
        chk("fetch1_sr2", {29'd0, if_id_sr2}, 32'd2);
        chk("addr4", {16'd0, imem_address}, 32'h0004);

        // Load-use stall: response buffered, IF/ID frozen
        load_if_id = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_read", {31'd0, imem_read}, 32'd0);
            chk("hold_ir", {15'd0, if_id_valid, if_id_ir}, {15'd0, 1'b1, 16'h5042});
        end
        load_if_id = 1'b1; mem_on = 1'b0;
        push_exp(mem_word(16'h0004), 16'h0006);
        tick();
        chk_ifid("release");
        chk("release_read", {31'd0, imem_read}, 32'd1);
        chk("release_addr", {16'd0, imem_address}, 32'h0006);

        // Redirect while a request is outstanding -> drain
        branch_taken = 1'b1; branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        chk_bubble("drain0");
        chk("drain0_addr", {16'd0, imem_address}, 32'h0006);
        chk("drain0_read", {31'd0, imem_read}, 32'd1);
        tick();
        chk("drain1_addr", {16'd0, imem_address}, 32'h0006);
        chk("drain1_valid", {31'd0, if_id_valid}, 32'd0);
        mem_on = 1'b1;
        tick();
        chk("drain_done_addr", {16'd0, imem_address}, 32'h0040);
        chk("drain_done_valid", {31'd0, if_id_valid}, 32'd0);
        push_exp(mem_word(16'h0040), 16'h0042);
        tick();
        chk_ifid("target");

        // Global stall masks a taken branch
        pipe_stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0080;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("frz_ir", {15'd0, if_id_valid, if_id_ir}, {15'd0, 1'b1, mem_word(16'h0040)});
            chk("frz_pc", {16'd0, if_id_pc}, 32'h0042);
        end
        pipe_stall = 1'b0;
        tick();
        branch_taken = 1'b0;
        chk("unfrz_valid", {31'd0, if_id_valid}, 32'd0);
        chk("unfrz_addr", {16'd0, imem_address}, 32'h0080);
        chk("unfrz_read", {31'd0, imem_read}, 32'd1);
        push_exp(mem_word(16'h0080), 16'h0082);
        tick();
        chk_ifid("after_frz");

        // PC wrap at 0xFFFE
        branch_taken = 1'b1; branch_target = 16'hfffe;
        tick();
        branch_taken = 1'b0;
        chk("wrap_redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("wrap_redir_addr", {16'd0, imem_address}, 32'hfffe);
        push_exp(mem_word(16'hfffe), 16'h0000);
        tick();
        chk_ifid("wrap");
        chk("wrap_addr", {16'd0, imem_address}, 32'h0000);

        // Reset in the middle of HOLD
        load_if_id = 1'b0;
        tick();
        chk("hold2_read", {31'd0, imem_read}, 32'd0);
        rst = 1'b1;
        tick();
        chk("rst2_read", {31'd0, imem_read}, 32'd0);
        chk("rst2_addr", {16'd0, imem_address}, 32'h0000);
        chk_bubble("rst2_ifid");
        rst = 1'b0; load_if_id = 1'b1;
        tick();
        chk("restart_read", {31'd0, imem_read}, 32'd1);
        chk("restart_addr", {16'd0, imem_address}, 32'h0000);
        push_exp(16'h1261, 16'h0002);
        tick();
        chk_ifid("restart");
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
